alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle combinational ALU, with the same 6-bit opcode encoding.
- Operands enter through a valid/ready handshake. Results and flags (Z, N, C, V, ERR) leave two cycles later through a valid/ready output port carrying a caller tag.
- Sits between the control unit's issue logic and the writeback/branch logic, and tolerates writeback backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range >= 8.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts; transfer when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B / shift amount.
- in_op  in  6  opcode.
- in_cin  in  1  carry/borrow in (ADD/SUB only).
- in_tag  in  TAG_W  caller tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_res  out  WIDTH  result.
- out_c  out  1  carry (ADD), borrow (SUB), else 0.
- out_v  out  1  signed overflow (ADD/SUB), else 0.
- out_z  out  1  out_res == 0.
- out_n  out  1  out_res[WIDTH-1].
- out_err  out  1  illegal opcode.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Opcodes:
  - 010000 ADD: {C,res} = a+b+cin.
  - 010001 SUB: res = a-b-cin; C = 1 iff b+cin > a, unsigned, computed at WIDTH+1 bits.
  - 100000 EQ, 100001 NE, 100010 LE (unsigned), 100011 GT (unsigned): res = 1 or 0, zero-extended.
  - 110000 SLL, 110001 SRL, 110010 SRA: shift amount is the full unsigned b. If b >= WIDTH, SLL/SRL give 0 and SRA gives all copies of a[WIDTH-1].
- Overflow: V for ADD = (a[msb]==b[msb]) && (res[msb]!=a[msb]); for SUB = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
- Illegal opcode: res = 0, C = V = 0, ERR = 1. Z and N follow res as normal, giving Z = 1.
- Pipeline structure:
  - Stage 1 registers the operands, op, cin and tag on acceptance.
  - Stage 2 registers res, C, V, ERR and tag from the stage-1 contents. Z and N are registered in stage 2 from the computed res.
- Latency: an operation accepted at edge k is presented with out_valid at edge k+2 when out_ready is held high.
- Throughput: 1 op/cycle when unstalled.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready by design).
  - Stalled stages hold all fields stable; out_* is stable while out_valid && !out_ready.
- Simultaneous accept and drain in the same cycle is legal. There is no bubble when both stages are full and out_ready = 1.
- Reset (any time, including mid-operation):
  - s1_valid = s2_valid = 0; in-flight operations are discarded.
  - out_valid = 0, out_res = 0, all flags 0, out_tag = 0.
  - in_ready reads 1 while rst is high.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 010010 MUL is legal.
  - res = low WIDTH bits of unsigned a*b.
  - C = 1 iff the high WIDTH bits are nonzero; V = 0.
  - Computed in stage 2 with the same 2-cycle latency.
- Undefined: 010010 is illegal and yields ERR = 1, res = 0; no multiplier is synthesised.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_SLL, OP_SRL, OP_SRA, OP_MUL;
  - the flag struct alu_flags_t {c, v, z, n, err};
  - the function op_is_legal().
- One combinational sub-module, alu_exec, parametrised by WIDTH, computing res, C, V and ERR from a, b, op and cin. alu_pipe instantiates it between stage 1 and stage 2.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, cin = 0, out_ready = 1 -> out_valid 2 cycles after accept, res = 0, C = 1, Z = 1, V = 0, N = 0.
- SUB 0x80000000 - 0x00000001, cin = 0 -> res = 0x7FFFFFFF, V = 1, C = 0, N = 0. SUB 5 - 5, cin = 1 -> res = 0xFFFFFFFF, C = 1, N = 1.
- SRA a = 0x80000000, b = 40 -> res = 0xFFFFFFFF. SLL a = 1, b = 31 -> 0x80000000, N = 1. SRL a = 0xF0, b = 32 -> 0, Z = 1.
- Back-to-back tags 1, 2, 3 while out_ready is held 0 for 3 cycles:
  - in_ready drops after 2 accepts;
  - out_res and out_tag stay at tag 1 values;
  - on out_ready = 1, results drain in order 1, 2, 3 with no loss or duplication.
- Illegal opcode 0x3F -> ERR = 1, res = 0, Z = 1. With ALU_PIPE_MUL_EN, MUL 0x00010000 * 0x00010000 -> res = 0, C = 1; without the macro the same op gives ERR = 1.
- Assert rst while both stages are valid -> out_valid = 0 immediately (asynchronous), and no stale result emerges after rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bundle and opcode legality for the pipelined ALU.
// Build option: ALU_PIPE_MUL_EN makes opcode 010010 (MUL) legal.
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
  localparam logic [OP_W-1:0] OP_MUL = 6'b010010;
  localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
  localparam logic [OP_W-1:0] OP_NE  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
  localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
  localparam logic [OP_W-1:0] OP_SLL = 6'b110000;
  localparam logic [OP_W-1:0] OP_SRL = 6'b110001;
  localparam logic [OP_W-1:0] OP_SRA = 6'b110010;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
    logic err;
  } alu_flags_t;

  // True for every opcode this build implements
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational execute core: result, carry/borrow, overflow and illegal-op flag.
// Build option: ALU_PIPE_MUL_EN adds the unsigned multiplier for OP_MUL.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o,
  output logic             err_o
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           b_big;

  // One extra bit keeps the carry out of ADD and the borrow out of SUB
  assign sum   = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_i);
  assign diff  = {1'b0, a_i} - {1'b0, b_i} - (WIDTH+1)'(cin_i);
  assign b_big = (b_i >= WIDTH'(WIDTH));

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
`endif

  // Opcode decode; unknown opcodes leave res/C/V at zero
  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    err_o = !op_is_legal(op_i);
    case (op_i)
      OP_ADD: begin
        res_o = sum[WIDTH-1:0];
        c_o   = sum[WIDTH];
        v_o   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = diff[WIDTH-1:0];
        c_o   = diff[WIDTH];
        v_o   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_EQ:  res_o = WIDTH'(a_i == b_i);
      OP_NE:  res_o = WIDTH'(a_i != b_i);
      OP_LE:  res_o = WIDTH'(a_i <= b_i);
      OP_GT:  res_o = WIDTH'(a_i > b_i);
      OP_SLL: res_o = b_big ? '0 : (a_i << b_i);
      OP_SRL: res_o = b_big ? '0 : (a_i >> b_i);
      OP_SRA: res_o = b_big ? {WIDTH{a_i[MSB]}} : WIDTH'($signed(a_i) >>> b_i);
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        res_o = prod[WIDTH-1:0];
        c_o   = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a pass-through tag.
// Build option: ALU_PIPE_MUL_EN enables the MUL opcode in the execute core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [OP_W-1:0]  s1_op_q;
  logic             s1_cin_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  alu_flags_t       s2_flags_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] res_d;
  alu_flags_t       flags_d;
  logic             exec_c;
  logic             exec_v;
  logic             exec_err;

  // A stage may advance when it is empty or its successor advances
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  alu_exec #(.WIDTH(WIDTH)) u_exec (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .cin_i (s1_cin_q),
    .res_o (res_d),
    .c_o   (exec_c),
    .v_o   (exec_v),
    .err_o (exec_err)
  );

  // Assemble the stage-2 flag word, deriving Z and N from the computed result
  always_comb begin
    flags_d     = '0;
    flags_d.c   = exec_c;
    flags_d.v   = exec_v;
    flags_d.err = exec_err;
    flags_d.z   = (res_d == '0);
    flags_d.n   = res_d[WIDTH-1];
  end

  // Stage 1: capture the offered operation on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_op_q  <= in_op;
        s1_cin_q <= in_cin;
        s1_tag_q <= in_tag;
      end
    end
  end

  // Stage 2: register the executed result; holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q   <= res_d;
        s2_flags_q <= flags_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_c     = s2_flags_q.c;
  assign out_v     = s2_flags_q.v;
  assign out_z     = s2_flags_q.z;
  assign out_n     = s2_flags_q.n;
  assign out_err   = s2_flags_q.err;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed + randomised scoreboard bench for alu_pipe (WIDTH=32, TAG_W=4).
// Honours ALU_PIPE_MUL_EN in its reference model.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_op;
  logic        in_cin;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_c;
  logic        out_v;
  logic        out_z;
  logic        out_n;
  logic        out_err;
  logic [3:0]  out_tag;

  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];
  logic [5:0] ops [11];

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_err   (out_err),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written with 64-bit arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] op, input logic cin,
                                 input logic [3:0] tag);
    exp_t        e;
    logic [63:0] wa;
    logic [63:0] wb;
    logic [63:0] wr;
    longint      sr;
    e     = '0;
    e.tag = tag;
    wa    = {32'b0, a};
    wb    = {32'b0, b};
    case (op)
      6'h10: begin
        wr    = wa + wb + 64'(cin);
        e.res = wr[31:0];
        e.c   = wr[32];
        sr    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        e.v   = (sr > longint'(32'sh7FFFFFFF)) || (sr < longint'(32'sh80000000));
      end
      6'h11: begin
        wr    = wa - wb - 64'(cin);
        e.res = wr[31:0];
        e.c   = (wb + 64'(cin)) > wa;
        sr    = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        e.v   = (sr > longint'(32'sh7FFFFFFF)) || (sr < longint'(32'sh80000000));
      end
      6'h20: e.res = (a == b) ? 32'd1 : 32'd0;
      6'h21: e.res = (a != b) ? 32'd1 : 32'd0;
      6'h22: e.res = (wa <= wb) ? 32'd1 : 32'd0;
      6'h23: e.res = (wa > wb) ? 32'd1 : 32'd0;
      6'h30: e.res = (b >= 32) ? 32'd0 : (a << b[4:0]);
      6'h31: e.res = (b >= 32) ? 32'd0 : (a >> b[4:0]);
      6'h32: begin
        wr    = {{32{a[31]}}, a} >> b[4:0];
        e.res = (b >= 32) ? {32{a[31]}} : wr[31:0];
      end
`ifdef ALU_PIPE_MUL_EN
      6'h12: begin
        wr    = wa * wb;
        e.res = wr[31:0];
        e.c   = |wr[63:32];
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, got, exp);
    end
  endtask

  // One clock: log acceptance, score any output transfer, then advance
  task automatic step(output bit acc);
    exp_t e;
    exp_t obs;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_out observed tag %0d expected none", out_tag);
      end else begin
        e   = exp_q.pop_front();
        obs = {out_res, out_c, out_v, out_z, out_n, out_err, out_tag};
        assert (obs === e) else begin
          errors++;
          $error("FAIL result_tag%0d observed %h expected %h", e.tag, obs, e);
        end
      end
    end
    if (acc) exp_q.push_back(model(in_a, in_b, in_op, in_cin, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [3:0] tag);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_tag   = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      step(acc);
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(acc);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    ops = '{6'h10, 6'h11, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32, 6'h3F};
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_flags", 64'({out_c, out_v, out_z, out_n, out_err}), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: valid appears after the edge following acceptance
    send(6'h10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd1);
    chk("lat_after_accept", 64'(out_valid), 64'd0);
    step(acc);
    chk("lat_next_edge", 64'(out_valid), 64'd1);
    drain();

    // Arithmetic, compare, shift and illegal-op corners, issued back to back
    send(6'h11, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'd2);
    send(6'h11, 32'd5,         32'd5,         1'b1, 4'd3);
    send(6'h32, 32'h8000_0000, 32'd40,        1'b0, 4'd4);
    send(6'h30, 32'd1,         32'd31,        1'b0, 4'd5);
    send(6'h31, 32'h0000_00F0, 32'd32,        1'b0, 4'd6);
    send(6'h10, 32'h7FFF_FFFF, 32'd1,         1'b0, 4'd7);
    send(6'h20, 32'h1234_5678, 32'h1234_5678, 1'b0, 4'd8);
    send(6'h21, 32'h1234_5678, 32'h1234_5678, 1'b0, 4'd9);
    send(6'h22, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd10);
    send(6'h23, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd11);
    send(6'h3F, 32'hDEAD_BEEF, 32'h1,         1'b1, 4'd12);
    send(6'h12, 32'h0001_0000, 32'h0001_0000, 1'b0, 4'd13);
    send(6'h32, 32'h8000_0010, 32'd4,         1'b0, 4'd14);
    send(6'h11, 32'd0,         32'hFFFF_FFFF, 1'b1, 4'd15);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    send(6'h10, 32'd3,  32'd4, 1'b0, 4'd1);
    send(6'h11, 32'd10, 32'd3, 1'b0, 4'd2);
    in_valid = 1'b1; in_op = 6'h20; in_a = 32'd7; in_b = 32'd7; in_cin = 1'b0; in_tag = 4'd3;
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_tag", 64'(out_tag), 64'd1);
      chk("stall_res", 64'(out_res), 64'd7);
      step(acc);
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    in_valid = 1'b0;
    chk("stall_t3_accepted", 64'(acc), 64'd1);
    drain();

    // Asynchronous reset with both stages full discards everything
    out_ready = 1'b0;
    send(6'h10, 32'd100, 32'd1, 1'b0, 4'd5);
    send(6'h10, 32'd200, 32'd1, 1'b0, 4'd6);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) step(acc);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = ops[$urandom_range(0, 10)];
      in_a      = $urandom;
      in_b      = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
      in_cin    = 1'($urandom_range(0, 1));
      in_tag    = 4'(i);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
